// File: rtl/l2_cache_control_nway_pkg.sv
// cache_mux_types: shared select and state encodings for the L2 controller
package cache_mux_types;
    typedef enum logic [1:0] {no_write, cpu_write_cache, mem_write_cache} dataarraymux_sel_t;
    typedef enum logic {cache_read_mem, cache_write_mem} pmemaddressmux_sel_t;
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WRITE} l2_state_t;
endpackage

// File: rtl/l2_cache_control_nway_if.sv
// l2_cache_control_nway_if: CPU, memory and datapath signals of the L2 controller
interface l2_cache_control_nway_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = $clog2(NUM_SETS)
);
    import cache_mux_types::*;
    logic                mem_read;
    logic                mem_write;
    logic                mem_resp;
    logic [SET_W-1:0]    set_idx;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [NUM_WAYS-1:0] valid_vec;
    logic [NUM_WAYS-1:0] dirty_vec;
    logic                pmem_read;
    logic                pmem_write;
    logic                pmem_resp;
    logic [NUM_WAYS-1:0] valid_load;
    logic [NUM_WAYS-1:0] dirty_load;
    logic [NUM_WAYS-1:0] tag_load;
    logic                valid_datain;
    logic                dirty_datain;
    dataarraymux_sel_t   data_we_sel [NUM_WAYS];
    dataarraymux_sel_t   data_din_sel [NUM_WAYS];
    logic                mbr_load;
    logic [WAY_W-1:0]    dataout_sel;
    pmemaddressmux_sel_t pmem_address_sel;
    logic                multi_hit_err;

    modport master (
        input  mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
        output mem_resp, pmem_read, pmem_write, valid_load, dirty_load, tag_load,
               valid_datain, dirty_datain, data_we_sel, data_din_sel, mbr_load,
               dataout_sel, pmem_address_sel, multi_hit_err
    );

    modport slave (
        output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, valid_load, dirty_load, tag_load,
               valid_datain, dirty_datain, data_we_sel, data_din_sel, mbr_load,
               dataout_sel, pmem_address_sel, multi_hit_err
    );
endinterface

// File: rtl/l2_cache_control_nway_plru_tree.sv
// plru_tree: tree pseudo-LRU victim pick and update for one set (node i has children 2i+1, 2i+2)
module plru_tree #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] bits,
    input  logic [WAY_W-1:0]    access_way,
    output logic [WAY_W-1:0]    victim_way,
    output logic [NUM_WAYS-2:0] next_bits
);
    localparam logic [NUM_WAYS-2:0] NODE_ONE = (NUM_WAYS-1)'(1);
    localparam logic [WAY_W-1:0] WAY_ONE = WAY_W'(1);

    // Follow each node bit from the root; a 0 bit steers to the lower-index subtree
    always_comb begin
        logic [WAY_W-1:0] n;
        logic b;
        victim_way = '0;
        n = '0;
        b = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            b = |(bits & (NODE_ONE << n));
            victim_way = WAY_W'(2 * int'(victim_way) + int'(b));
            n = WAY_W'(2 * int'(n) + 1 + int'(b));
        end
    end

    // Walk toward the accessed way, pointing every node on the path at the other side
    always_comb begin
        logic [WAY_W-1:0] n;
        logic a;
        next_bits = bits;
        n = '0;
        a = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            a = |(access_way & (WAY_ONE << (WAY_W - 1 - l)));
            next_bits = a ? next_bits & ~(NODE_ONE << n) : next_bits | (NODE_ONE << n);
            n = WAY_W'(2 * int'(n) + 1 + int'(a));
        end
    end
endmodule

// File: rtl/l2_cache_control_nway.sv
// l2_cache_control_nway: write-back write-allocate N-way L2 control FSM with per-set tree PLRU
module l2_cache_control_nway
    import cache_mux_types::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input logic clk,
    input logic rst,
    l2_cache_control_nway_if.master bus
);
    l2_state_t           state_q, state_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [NUM_WAYS-2:0] plru_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_next;
    logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, access_way;
    logic                req, is_write, hit, any_invalid, plru_we;

    assign req = bus.mem_read | bus.mem_write;
    assign is_write = bus.mem_write & ~bus.mem_read;
    assign hit = |bus.hit_vec;
    assign any_invalid = ~&bus.valid_vec;
    assign access_way = (state_q == LOOKUP) ? hit_way : victim_q;
    assign bus.multi_hit_err = (state_q == LOOKUP) && ((bus.hit_vec & (bus.hit_vec - NUM_WAYS'(1))) != '0);

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits       (plru_q[bus.set_idx]),
        .access_way (access_way),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    // Lowest-index hit way and lowest-index invalid way
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.hit_vec[i]) hit_way = WAY_W'(i);
            if (!bus.valid_vec[i]) inv_way = WAY_W'(i);
        end
    end

    // State, victim and per-set replacement registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q <= state_d;
            victim_q <= victim_d;
            if (plru_we) plru_q[bus.set_idx] <= plru_next;
        end
    end

    // Next state and datapath/memory controls
    always_comb begin
        state_d = state_q;
        victim_d = victim_q;
        plru_we = 1'b0;
        bus.mem_resp = 1'b0;
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        bus.valid_load = '0;
        bus.dirty_load = '0;
        bus.tag_load = '0;
        bus.valid_datain = 1'b0;
        bus.dirty_datain = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            bus.data_we_sel[w] = no_write;
            bus.data_din_sel[w] = no_write;
        end
        bus.mbr_load = 1'b0;
        bus.dataout_sel = '0;
        bus.pmem_address_sel = cache_read_mem;
        case (state_q)
            IDLE: state_d = req ? LOOKUP : IDLE;
            LOOKUP: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    bus.mem_resp = 1'b1;
                    plru_we = 1'b1;
                    state_d = IDLE;
                    if (is_write) begin
                        bus.dirty_load[hit_way] = 1'b1;
                        bus.dirty_datain = 1'b1;
                        bus.data_we_sel[hit_way] = cpu_write_cache;
                        bus.data_din_sel[hit_way] = cpu_write_cache;
                    end else begin
                        bus.dataout_sel = hit_way;
                    end
                end else begin
                    victim_d = any_invalid ? inv_way : plru_victim;
                    state_d = (bus.valid_vec[victim_d] && bus.dirty_vec[victim_d]) ? WRITEBACK : FILL_REQ;
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.pmem_address_sel = cache_write_mem;
                bus.dataout_sel = victim_q;
                if (bus.pmem_resp) begin
                    bus.valid_load[victim_q] = 1'b1;
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                bus.pmem_read = 1'b1;
                bus.mbr_load = 1'b1;
                state_d = bus.pmem_resp ? FILL_WRITE : FILL_REQ;
            end
            FILL_WRITE: begin
                bus.tag_load[victim_q] = 1'b1;
                bus.valid_load[victim_q] = 1'b1;
                bus.dirty_load[victim_q] = 1'b1;
                bus.valid_datain = 1'b1;
                bus.data_we_sel[victim_q] = mem_write_cache;
                bus.data_din_sel[victim_q] = mem_write_cache;
                plru_we = 1'b1;
                state_d = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_l2_cache_control_nway.sv
// tb_l2_cache_control_nway: randomized cache traffic checked against a behavioural cache/PLRU model
module tb_l2_cache_control_nway;
    import cache_mux_types::*;
    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 8;
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    typedef struct packed {
        logic                  mem_resp;
        logic                  pmem_read;
        logic                  pmem_write;
        logic [NUM_WAYS-1:0]   valid_load;
        logic [NUM_WAYS-1:0]   dirty_load;
        logic [NUM_WAYS-1:0]   tag_load;
        logic                  valid_datain;
        logic                  dirty_datain;
        logic [2*NUM_WAYS-1:0] we;
        logic [2*NUM_WAYS-1:0] din;
        logic                  mbr_load;
        logic [WAY_W-1:0]      dataout_sel;
        logic                  addr_sel;
        logic                  multi;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_cache_control_nway_if #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) bus ();
    l2_cache_control_nway #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cmp = 0;
    int bad = 0;
    bit m_valid [NUM_SETS][NUM_WAYS];
    bit m_dirty [NUM_SETS][NUM_WAYS];
    int m_tag [NUM_SETS][NUM_WAYS];
    bit m_plru [NUM_SETS][NUM_WAYS-1];

    function automatic out_t observe();
        out_t o;
        o = '0;
        o.mem_resp = bus.mem_resp;
        o.pmem_read = bus.pmem_read;
        o.pmem_write = bus.pmem_write;
        o.valid_load = bus.valid_load;
        o.dirty_load = bus.dirty_load;
        o.tag_load = bus.tag_load;
        o.valid_datain = bus.valid_datain;
        o.dirty_datain = bus.dirty_datain;
        for (int w = 0; w < NUM_WAYS; w++) begin
            o.we[2*w +: 2] = bus.data_we_sel[w];
            o.din[2*w +: 2] = bus.data_din_sel[w];
        end
        o.mbr_load = bus.mbr_load;
        o.dataout_sel = bus.dataout_sel;
        o.addr_sel = bus.pmem_address_sel;
        o.multi = bus.multi_hit_err;
        return o;
    endfunction

    function automatic int model_hit(input int s, input int t);
        for (int w = 0; w < NUM_WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int model_victim(input int s);
        int lo = 0, hi = NUM_WAYS, n = 0, mid;
        for (int w = 0; w < NUM_WAYS; w++) if (!m_valid[s][w]) return w;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_plru[s][n]) begin lo = mid; n = 2*n + 2; end
            else begin hi = mid; n = 2*n + 1; end
        end
        return lo;
    endfunction

    function automatic void model_touch(input int s, input int a);
        int lo = 0, hi = NUM_WAYS, n = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (a < mid) begin m_plru[s][n] = 1'b1; hi = mid; n = 2*n + 1; end
            else begin m_plru[s][n] = 1'b0; lo = mid; n = 2*n + 2; end
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) for (int n = 0; n < NUM_WAYS - 1; n++) m_plru[s][n] = 1'b0;
    endfunction

    task automatic drive_vecs(input int s, input int t);
        bus.set_idx = SET_W'(s);
        for (int w = 0; w < NUM_WAYS; w++) begin
            bus.hit_vec[w] = m_valid[s][w] && m_tag[s][w] == t;
            bus.valid_vec[w] = m_valid[s][w];
            bus.dirty_vec[w] = m_dirty[s][w];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input int s, input int t, input bit rd, input bit wr);
        out_t e;
        int w, v, lat;
        bit is_wr;
        is_wr = wr && !rd;
        bus.mem_read = rd;
        bus.mem_write = wr;
        drive_vecs(s, t);
        #1;
        e = '0;
        cmp++;
        if (observe() !== e) begin bad++; $display("FAIL idle_req: got %h want %h", observe(), e); end
        step();
        drive_vecs(s, t);
        #1;
        w = model_hit(s, t);
        if (w < 0) begin
            v = model_victim(s);
            e = '0;
            cmp++;
            if (observe() !== e) begin bad++; $display("FAIL lookup_miss: got %h want %h", observe(), e); end
            step();
            if (m_valid[s][v] && m_dirty[s][v]) begin
                lat = $urandom_range(1, 3);
                for (int i = 0; i < lat; i++) begin
                    bus.pmem_resp = (i == lat - 1);
                    #1;
                    e = '0;
                    e.pmem_write = 1'b1;
                    e.addr_sel = 1'b1;
                    e.dataout_sel = WAY_W'(v);
                    e.valid_load[v] = (i == lat - 1);
                    cmp++;
                    if (observe() !== e) begin bad++; $display("FAIL writeback: got %h want %h", observe(), e); end
                    step();
                end
                bus.pmem_resp = 1'b0;
                m_valid[s][v] = 1'b0;
                drive_vecs(s, t);
            end
            lat = $urandom_range(1, 4);
            for (int i = 0; i < lat; i++) begin
                bus.pmem_resp = (i == lat - 1);
                #1;
                e = '0;
                e.pmem_read = 1'b1;
                e.mbr_load = 1'b1;
                cmp++;
                if (observe() !== e) begin bad++; $display("FAIL fill_req: got %h want %h", observe(), e); end
                step();
            end
            bus.pmem_resp = 1'b0;
            #1;
            e = '0;
            e.tag_load[v] = 1'b1;
            e.valid_load[v] = 1'b1;
            e.dirty_load[v] = 1'b1;
            e.valid_datain = 1'b1;
            e.we[2*v +: 2] = mem_write_cache;
            e.din[2*v +: 2] = mem_write_cache;
            cmp++;
            if (observe() !== e) begin bad++; $display("FAIL fill_write: got %h want %h", observe(), e); end
            step();
            m_tag[s][v] = t;
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            model_touch(s, v);
            drive_vecs(s, t);
            #1;
            w = v;
        end
        e = '0;
        e.mem_resp = 1'b1;
        if (is_wr) begin
            e.dirty_load[w] = 1'b1;
            e.dirty_datain = 1'b1;
            e.we[2*w +: 2] = cpu_write_cache;
            e.din[2*w +: 2] = cpu_write_cache;
        end else begin
            e.dataout_sel = WAY_W'(w);
        end
        cmp++;
        if (observe() !== e) begin bad++; $display("FAIL lookup_hit: got %h want %h", observe(), e); end
        step();
        model_touch(s, w);
        if (is_wr) m_dirty[s][w] = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        cmp++;
        if (observe() !== out_t'('0)) begin bad++; $display("FAIL reset_outputs: got %h want %h", observe(), out_t'('0)); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_cold_miss();
        run_access(2, 10, 1'b1, 1'b0);
    endtask

    task automatic test_plru_fill();
        for (int i = 1; i < NUM_WAYS; i++) run_access(2, 10 + i, 1'b1, 1'b0);
        run_access(2, 11, 1'b1, 1'b0);
        run_access(2, 20, 1'b1, 1'b0);
    endtask

    task automatic test_write_hit();
        run_access(2, m_tag[2][NUM_WAYS-1], 1'b0, 1'b1);
        run_access(2, m_tag[2][0], 1'b1, 1'b1);
    endtask

    task automatic test_dirty_miss();
        for (int w = 0; w < NUM_WAYS; w++) run_access(2, m_tag[2][w], 1'b0, 1'b1);
        run_access(2, 30, 1'b1, 1'b0);
    endtask

    task automatic test_multi_hit();
        out_t e;
        int ew;
        ew = (NUM_WAYS > 2) ? 1 : 0;
        bus.mem_read = 1'b1;
        bus.set_idx = SET_W'(1);
        bus.hit_vec = (NUM_WAYS > 2) ? NUM_WAYS'(6) : NUM_WAYS'(3);
        bus.valid_vec = '1;
        bus.dirty_vec = '0;
        #1;
        e = '0;
        cmp++;
        if (observe() !== e) begin bad++; $display("FAIL multi_idle: got %h want %h", observe(), e); end
        step();
        e.mem_resp = 1'b1;
        e.dataout_sel = WAY_W'(ew);
        e.multi = 1'b1;
        cmp++;
        if (observe() !== e) begin bad++; $display("FAIL multi_lookup: got %h want %h", observe(), e); end
        step();
        model_touch(1, ew);
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_t e;
        bus.mem_read = 1'b1;
        drive_vecs(3, 99);
        step();
        step();
        e = '0;
        e.pmem_read = 1'b1;
        e.mbr_load = 1'b1;
        cmp++;
        if (observe() !== e) begin bad++; $display("FAIL pre_reset_fill: got %h want %h", observe(), e); end
        rst = 1'b1;
        step();
        cmp++;
        if (observe() !== out_t'('0)) begin bad++; $display("FAIL mid_reset: got %h want %h", observe(), out_t'('0)); end
        rst = 1'b0;
        bus.mem_read = 1'b0;
        model_reset();
        step();
        cmp++;
        if (observe() !== out_t'('0)) begin bad++; $display("FAIL post_reset_idle: got %h want %h", observe(), out_t'('0)); end
        run_access(2, 50, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int s, t, r, g;
        for (int k = 0; k < 200; k++) begin
            s = $urandom_range(0, NUM_SETS - 1);
            t = $urandom_range(0, NUM_WAYS + 3);
            r = $urandom_range(0, 3);
            run_access(s, t, r != 1, r == 1 || r == 2);
            g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
                #1;
                cmp++;
                if (observe() !== out_t'('0)) begin bad++; $display("FAIL idle_gap: got %h want %h", observe(), out_t'('0)); end
                step();
            end
        end
    endtask

    initial begin
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.set_idx = '0;
        bus.hit_vec = '0;
        bus.valid_vec = '0;
        bus.dirty_vec = '0;
        test_reset();
        test_cold_miss();
        test_plru_fill();
        test_write_hit();
        test_dirty_miss();
        test_multi_hit();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end
endmodule
